detection_monitor: RTL and testbench

Downstream consumer of the Moore and Mealy sequence-detector outputs. It counts detections from each machine, stretches each single-cycle detection pulse so it is visible on an LED, and cross-checks the two machines against each other. The Mealy pulse for a sequence must be followed by the Moore pulse for the same sequence exactly `MAX_LAG` cycles later; any deviation latches a sticky fault with a captured fault kind.

---
 rtl/detection_monitor_pkg.sv | 20 ++
 rtl/detection_monitor_pulse_stretcher.sv | 42 ++++
 rtl/detection_monitor.sv | 117 +++++++++++
 tb/tb_detection_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/detection_monitor_pkg.sv
// Shared types for the detection monitor: cross-check FSM states and fault kinds.
package detection_monitor_pkg;

    typedef enum logic {
        S_OK    = 1'b0,
        S_FAULT = 1'b1
    } mon_state_t;

    typedef enum logic [1:0] {
        FK_NONE     = 2'b00,
        FK_SPURIOUS = 2'b01,
        FK_MISSING  = 2'b10
    } fault_kind_t;

    // A mismatch with Moore high means no Mealy pulse announced it.
    function automatic fault_kind_t classify_mismatch(input logic moore);
        return moore ? FK_SPURIOUS : FK_MISSING;
    endfunction

endpackage

// File: rtl/detection_monitor_pulse_stretcher.sv
// Retriggerable pulse stretcher: a single-cycle pulse keeps led_out high for CYCLES cycles.
module pulse_stretcher #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pulse_in,
    output logic led_out
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          led_q;

    // Reload on a pulse (retrigger, not extend), otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (pulse_in) begin
            cnt_d = CW'(CYCLES);
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timer and registered LED state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= {CW{1'b0}};
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= (cnt_d != {CW{1'b0}});
        end
    end

    assign led_out = led_q;

endmodule

// File: rtl/detection_monitor.sv
// Counts Moore/Mealy detections, stretches them onto LEDs and checks that every
// Mealy pulse is echoed by a Moore pulse exactly MAX_LAG cycles later.
module detection_monitor
    import detection_monitor_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int STRETCH_CYCLES = 4,
    parameter int MAX_LAG        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             moore_detected,
    input  logic             mealy_detected,
    input  logic             clear,
    output logic [CNT_W-1:0] moore_count,
    output logic [CNT_W-1:0] mealy_count,
    output logic             moore_led,
    output logic             mealy_led,
    output logic             fault,
    output logic [1:0]       fault_kind
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]   moore_cnt_q, moore_cnt_d;
    logic [CNT_W-1:0]   mealy_cnt_q, mealy_cnt_d;
    logic [MAX_LAG-1:0] pend_q, pend_d;
    mon_state_t         state_q, state_d;
    fault_kind_t        kind_q, kind_d;
    logic               fault_q;
    logic               exp_s;

    assign exp_s = pend_q[MAX_LAG-1];

    // Saturating counters and the Mealy delay line.
    always_comb begin
        moore_cnt_d = moore_cnt_q;
        mealy_cnt_d = mealy_cnt_q;
        pend_d      = pend_q;
        if (moore_detected && (moore_cnt_q != CNT_MAX)) begin
            moore_cnt_d = moore_cnt_q + CNT_ONE;
        end else begin
            moore_cnt_d = moore_cnt_q;
        end
        if (mealy_detected && (mealy_cnt_q != CNT_MAX)) begin
            mealy_cnt_d = mealy_cnt_q + CNT_ONE;
        end else begin
            mealy_cnt_d = mealy_cnt_q;
        end
        pend_d[0] = mealy_detected;
        for (int i = 1; i < MAX_LAG; i++) begin
            pend_d[i] = pend_q[i-1];
        end
    end

    // Cross-check FSM: the first mismatch is latched and its kind frozen.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        case (state_q)
            S_OK: begin
                if (moore_detected != exp_s) begin
                    state_d = S_FAULT;
                    kind_d  = classify_mismatch(moore_detected);
                end else begin
                    state_d = S_OK;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: begin
                state_d = S_OK;
                kind_d  = FK_NONE;
            end
        endcase
    end

    // State registers; reset and clear both return everything to idle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            moore_cnt_q <= {CNT_W{1'b0}};
            mealy_cnt_q <= {CNT_W{1'b0}};
            pend_q      <= {MAX_LAG{1'b0}};
            state_q     <= S_OK;
            kind_q      <= FK_NONE;
            fault_q     <= 1'b0;
        end else begin
            moore_cnt_q <= moore_cnt_d;
            mealy_cnt_q <= mealy_cnt_d;
            pend_q      <= pend_d;
            state_q     <= state_d;
            kind_q      <= kind_d;
            fault_q     <= (state_d == S_FAULT);
        end
    end

    pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_moore_led (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .pulse_in (moore_detected),
        .led_out  (moore_led)
    );

    pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_mealy_led (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .pulse_in (mealy_detected),
        .led_out  (mealy_led)
    );

    assign moore_count = moore_cnt_q;
    assign mealy_count = mealy_cnt_q;
    assign fault       = fault_q;
    assign fault_kind  = kind_q;

endmodule

// File: tb/tb_detection_monitor.sv
// Two monitors (default parameters and CNT_W=4/STRETCH=3/MAX_LAG=3) checked
// cycle by cycle against an event-history reference model.
module tb_detection_monitor;

    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, clear0, moore0, mealy0;
    logic [7:0] mo_cnt0, me_cnt0;
    logic       mo_led0, me_led0, fault0;
    logic [1:0] kind0;

    logic       reset1, clear1, moore1, mealy1;
    logic [3:0] mo_cnt1, me_cnt1;
    logic       mo_led1, me_led1, fault1;
    logic [1:0] kind1;

    detection_monitor #(.CNT_W(8), .STRETCH_CYCLES(4), .MAX_LAG(1)) dut0 (
        .clk(clk), .reset(reset0), .moore_detected(moore0), .mealy_detected(mealy0),
        .clear(clear0), .moore_count(mo_cnt0), .mealy_count(me_cnt0),
        .moore_led(mo_led0), .mealy_led(me_led0), .fault(fault0), .fault_kind(kind0)
    );

    detection_monitor #(.CNT_W(4), .STRETCH_CYCLES(3), .MAX_LAG(3)) dut1 (
        .clk(clk), .reset(reset1), .moore_detected(moore1), .mealy_detected(mealy1),
        .clear(clear1), .moore_count(mo_cnt1), .mealy_count(me_cnt1),
        .moore_led(mo_led1), .mealy_led(me_led1), .fault(fault1), .fault_kind(kind1)
    );

    int P_LAG[2] = '{1, 3};
    int P_STR[2] = '{4, 3};
    int P_MAX[2] = '{255, 15};

    bit s_rs[2], s_cl[2], s_me[2], s_mo[2];
    bit drv_me[2][NCYC];
    bit hist[2][NCYC];

    int m_mo[2], m_me[2], last_mo[2], last_me[2], m_fault[2], m_kind[2], epoch[2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Stimulus: directed scenarios first, then random traffic with mostly matched Moore echoes.
    task automatic gen_stim(input int k, input int c);
        s_rs[k] = 1'b0;
        s_cl[k] = 1'b0;
        s_me[k] = 1'b0;
        s_mo[k] = 1'b0;
        if (c < 3) begin
            s_rs[k] = 1'b1;
        end else if (c < 150) begin
            if (k == 0) begin
                s_me[k] = (c inside {10, 20, 21, 22, 33, 40});
                s_mo[k] = (c inside {11, 21, 22, 23, 30});
                s_cl[k] = (c inside {37, 50});
            end else begin
                s_me[k] = (c == 60) || (c >= 100 && c < 120);
                s_mo[k] = (c >= 103 && c < 123);
                s_rs[k] = (c == 61);
            end
        end else begin
            s_rs[k] = ($urandom_range(0, 199) == 0);
            s_cl[k] = ($urandom_range(0, 99) == 0);
            s_me[k] = ($urandom_range(0, 2) == 0);
            s_mo[k] = drv_me[k][c - P_LAG[k]] ^ ($urandom_range(0, 149) == 0);
        end
        drv_me[k][c] = s_me[k];
    endtask

    // Reference: expected Moore at edge c is whatever Mealy did at edge c-LAG since the last reset.
    task automatic model_step(input int k, input int c);
        int e;
        if (s_rs[k] || s_cl[k]) begin
            m_mo[k] = 0;        m_me[k] = 0;
            last_mo[k] = -100000; last_me[k] = -100000;
            m_fault[k] = 0;     m_kind[k] = 0;
            epoch[k] = c + 1;
            hist[k][c] = 1'b0;
        end else begin
            hist[k][c] = s_me[k];
            if (s_mo[k]) begin
                if (m_mo[k] < P_MAX[k]) m_mo[k]++;
                last_mo[k] = c;
            end
            if (s_me[k]) begin
                if (m_me[k] < P_MAX[k]) m_me[k]++;
                last_me[k] = c;
            end
            e = 0;
            if (c - P_LAG[k] >= epoch[k]) e = int'(hist[k][c - P_LAG[k]]);
            if (m_fault[k] == 0 && int'(s_mo[k]) != e) begin
                m_fault[k] = 1;
                m_kind[k] = s_mo[k] ? 1 : 2;
            end
        end
    endtask

    function automatic int led_exp(input int k, input int c, input int last);
        return (c - last < P_STR[k]) ? 1 : 0;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mo[k] = 0; m_me[k] = 0; last_mo[k] = -100000; last_me[k] = -100000;
            m_fault[k] = 0; m_kind[k] = 0; epoch[k] = 0;
        end
        for (int c = 0; c < NCYC; c++) begin
            gen_stim(0, c);
            gen_stim(1, c);
            reset0 = s_rs[0]; clear0 = s_cl[0]; mealy0 = s_me[0]; moore0 = s_mo[0];
            reset1 = s_rs[1]; clear1 = s_cl[1]; mealy1 = s_me[1]; moore1 = s_mo[1];
            @(posedge clk);
            model_step(0, c);
            model_step(1, c);
            @(negedge clk);

            check_eq("d0_moore_count", int'(mo_cnt0), m_mo[0]);
            check_eq("d0_mealy_count", int'(me_cnt0), m_me[0]);
            check_eq("d0_moore_led",   int'(mo_led0), led_exp(0, c, last_mo[0]));
            check_eq("d0_mealy_led",   int'(me_led0), led_exp(0, c, last_me[0]));
            check_eq("d0_fault",       int'(fault0),  m_fault[0]);
            check_eq("d0_fault_kind",  int'(kind0),   m_kind[0]);

            check_eq("d1_moore_count", int'(mo_cnt1), m_mo[1]);
            check_eq("d1_mealy_count", int'(me_cnt1), m_me[1]);
            check_eq("d1_moore_led",   int'(mo_led1), led_exp(1, c, last_mo[1]));
            check_eq("d1_mealy_led",   int'(me_led1), led_exp(1, c, last_me[1]));
            check_eq("d1_fault",       int'(fault1),  m_fault[1]);
            check_eq("d1_fault_kind",  int'(kind1),   m_kind[1]);

            // Hand-derived checkpoints; output observed here is cycle c+1.
            if (c == 2) begin
                check_eq("rst_count0", int'(mo_cnt0) + int'(me_cnt0), 0);
                check_eq("rst_fault1", int'(fault1) + int'(kind1), 0);
            end
            if (c == 10) check_eq("nom_mealy_led_c11", int'(me_led0), 1);
            if (c == 13) check_eq("nom_mealy_led_c14", int'(me_led0), 1);
            if (c == 14) check_eq("nom_mealy_led_c15", int'(me_led0), 0);
            if (c == 14) check_eq("nom_moore_led_c15", int'(mo_led0), 1);
            if (c == 15) check_eq("nom_moore_led_c16", int'(mo_led0), 0);
            if (c == 11) check_eq("nom_counts", int'(mo_cnt0) * 16 + int'(me_cnt0), 17);
            if (c == 23) check_eq("ovl_counts", int'(mo_cnt0) * 16 + int'(me_cnt0), 68);
            if (c == 23) check_eq("ovl_fault", int'(fault0), 0);
            if (c == 26) check_eq("ovl_moore_led_c27", int'(mo_led0), 1);
            if (c == 27) check_eq("ovl_moore_led_c28", int'(mo_led0), 0);
            if (c == 29) check_eq("spur_fault_c30", int'(fault0), 0);
            if (c == 30) check_eq("spur_fault_c31", int'(fault0), 1);
            if (c == 30) check_eq("spur_kind_c31", int'(kind0), 1);
            if (c == 35) check_eq("spur_kind_sticky", int'(kind0), 1);
            if (c == 40) check_eq("miss_fault_c41", int'(fault0), 0);
            if (c == 41) check_eq("miss_kind_c42", int'(kind0), 2);
            if (c == 50) begin
                check_eq("clr_fault", int'(fault0) + int'(kind0), 0);
                check_eq("clr_counts", int'(mo_cnt0) + int'(me_cnt0), 0);
            end
            if (c == 61) check_eq("lag3_reset_fault", int'(fault1), 0);
            if (c == 64) check_eq("lag3_no_missing", int'(fault1), 0);
            if (c == 125) check_eq("sat_counts", int'(mo_cnt1) * 16 + int'(me_cnt1), 255);
            if (c == 125) check_eq("sat_fault", int'(fault1), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
